// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared types and constants for the load/store controller:
//   lsu_state_t  - controller FSM states
//   LB..LHU      - funct3 encodings of the memory ops
//   ERR_*        - codes reported on out_err
//   is_misaligned - alignment rule applied when an op is accepted
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_t;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    // Bytes never misalign; halves need addr[0]=0; words and the
    // unassigned encodings (treated as words) need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [2:0] op,
                                           input logic [1:0] off);
        logic mis;
        case (op)
            LB, LBU: mis = 1'b0;
            LH, LHU: mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align
// Purely combinational byte-lane steering for the load/store controller.
// Ports:
//   st_op, st_off, st_data  -> st_wdata, st_wmask : store data replicated
//                              across lanes and the 4-bit byte mask
//   ld_op, ld_off, ld_word  -> ld_data            : lane extraction plus
//                              sign/zero extension of a returned word
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_op,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wmask,
    input  logic [2:0]  ld_op,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store direction: replicating the data lets the mask alone pick the
    // lane, so no barrel shift of the data is needed.
    always_comb begin
        st_wdata = st_data;
        st_wmask = 4'hF;
        case (st_op)
            LB, LBU: begin
                st_wdata = {4{st_data[7:0]}};
                st_wmask = 4'b0001 << st_off;
            end
            LH, LHU: begin
                st_wdata = {2{st_data[15:0]}};
                st_wmask = 4'b0011 << st_off;
            end
            default: begin
                st_wdata = st_data;
                st_wmask = 4'hF;
            end
        endcase
    end

    // Load direction: pick the addressed lane, then extend per op.
    always_comb begin
        ld_byte = ld_word[7:0];
        case (ld_off)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

        ld_data = ld_word;
        case (ld_op)
            LB:      ld_data = {{24{ld_byte[7]}}, ld_byte};
            LBU:     ld_data = {24'd0, ld_byte};
            LH:      ld_data = {{16{ld_half[15]}}, ld_half};
            LHU:     ld_data = {16'd0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl
// Load/store controller between execute and the data-memory port.
// One op in flight; every output is a flop or a decode of the state.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   in_valid/in_ready              - op handshake from execute
//   in_wen, in_op, in_addr, in_wdata - op fields (funct3 encoding in in_op)
//   mem_req/mem_gnt                - request channel to data memory
//   mem_wen, mem_addr, mem_wdata, mem_wmask - request fields
//   mem_rvalid, mem_rdata          - memory response
//   out_valid/out_ready            - result handshake to write-back
//   out_rdata, out_err             - extended load data / error code
// Parameter TIMEOUT (>= 1): WAIT cycles before a bus timeout is reported.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_wen,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [1:0]  out_err
);

    // The counter only has to reach TIMEOUT-1.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t        state_q, state_d;
    logic              wen_q, wen_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        err_q, err_d;

    logic [31:0]       st_wdata;
    logic [3:0]        st_wmask;
    logic [31:0]       ld_data;

    // Store steering works on the incoming op; load extraction works on
    // the latched op/offset against the raw response word.
    lsu_align u_align (
        .st_op    (in_op),
        .st_off   (in_addr[1:0]),
        .st_data  (in_wdata),
        .st_wdata (st_wdata),
        .st_wmask (st_wmask),
        .ld_op    (op_q),
        .ld_off   (off_q),
        .ld_word  (mem_rdata),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wen_q   <= 1'b0;
            op_q    <= 3'd0;
            off_q   <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wmask_q <= 4'd0;
            cnt_q   <= '0;
            rdata_q <= 32'd0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            op_q    <= op_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        op_d    = op_q;
        off_d   = off_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    wen_d   = in_wen;
                    op_d    = in_op;
                    off_d   = in_addr[1:0];
                    addr_d  = {in_addr[31:2], 2'b00};
                    // Loads carry no write data or mask on the bus.
                    wdata_d = in_wen ? st_wdata : 32'd0;
                    wmask_d = in_wen ? st_wmask : 4'd0;
                    cnt_d   = '0;
                    rdata_d = 32'd0;
                    if (is_misaligned(in_op, in_addr[1:0])) begin
                        err_d   = ERR_MISALIGN;
                        state_d = S_RESP;
                    end else begin
                        err_d   = ERR_NONE;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response in the final counted cycle still wins.
                if (mem_rvalid) begin
                    rdata_d = wen_q ? 32'd0 : ld_data;
                    err_d   = ERR_NONE;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = 32'd0;
                    err_d   = ERR_TIMEOUT;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign mem_req   = (state_q == S_REQ);
    assign mem_wen   = wen_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = {4'd0, wmask_q};
    assign out_valid = (state_q == S_RESP);
    assign out_rdata = rdata_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl
// Directed bench for lsu_ctrl (TIMEOUT=4). Inputs change 1 time unit
// after the rising edge and outputs are sampled at that same point, so
// every sample sees settled registered values.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_wen;
    logic [2:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [1:0]  out_err;

    int numCompared   = 0;
    int numMismatched = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_wen     (in_wen),
        .in_op      (in_op),
        .in_addr    (in_addr),
        .in_wdata   (in_wdata),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rdata  (out_rdata),
        .out_err    (out_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        numCompared++;
        if (got !== exp) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents one op for a single cycle while the controller is idle.
    task automatic applyStimulus(input logic wen, input logic [2:0] op,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        in_valid = 1'b1;
        in_wen   = wen;
        in_op    = op;
        in_addr  = addr;
        in_wdata = wdata;
        tick();
        in_valid = 1'b0;
        in_wen   = 1'b0;
        in_op    = 3'd0;
        in_addr  = 32'd0;
        in_wdata = 32'd0;
    endtask

    // gntDelay REQ cycles without grant, then grant; rvDelay WAIT cycles
    // without response, then one response cycle (rvDelay < 0: never).
    task automatic serveBus(input int gntDelay, input int rvDelay,
                            input logic [31:0] rdata);
        for (int i = 0; i < gntDelay; i++) tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        if (rvDelay >= 0) begin
            for (int i = 0; i < rvDelay; i++) tick();
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'd0;
        end
    endtask

    task automatic releaseResp();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"},  in_ready,  1);
        checkOutput({tag, "_mem_req"},   mem_req,   0);
        checkOutput({tag, "_mem_wen"},   mem_wen,   0);
        checkOutput({tag, "_mem_addr"},  mem_addr,  0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
        checkOutput({tag, "_mem_wmask"}, mem_wmask, 0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_rdata"}, out_rdata, 0);
        checkOutput({tag, "_out_err"},   out_err,   0);
    endtask

    // Aligned load with minimum latency: accept, gnt, rvalid, result.
    task automatic loadCase(input string tag, input logic [2:0] op,
                            input logic [31:0] addr, input logic [31:0] rdata,
                            input logic [31:0] expData);
        applyStimulus(1'b0, op, addr, 32'd0);
        checkOutput({tag, "_req"},      mem_req,   1);
        checkOutput({tag, "_addr"},     mem_addr,  {addr[31:2], 2'b00});
        checkOutput({tag, "_wen"},      mem_wen,   0);
        checkOutput({tag, "_busy"},     in_ready,  0);
        checkOutput({tag, "_early"},    out_valid, 0);
        serveBus(0, 0, rdata);
        checkOutput({tag, "_valid"},    out_valid, 1);
        checkOutput({tag, "_rdata"},    out_rdata, expData);
        checkOutput({tag, "_err"},      out_err,   ERR_NONE);
        releaseResp();
        checkOutput({tag, "_idle"},     in_ready,  1);
        checkOutput({tag, "_done"},     out_valid, 0);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_wen     = 1'b0;
        in_op      = 3'd0;
        in_addr    = 32'd0;
        in_wdata   = 32'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        out_ready  = 1'b0;
        tick();
        tick();
        checkResetValues("reset");
        rst = 1'b0;
        tick();

        // Aligned loads and extension
        loadCase("lw",  LW,  32'h8000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        loadCase("lb",  LB,  32'h8000_0003, 32'h80FF_0000, 32'hFFFF_FF80);
        loadCase("lbu", LBU, 32'h8000_0003, 32'h80FF_0000, 32'h0000_0080);
        loadCase("lh",  LH,  32'h8000_0000, 32'h1234_8001, 32'hFFFF_8001);
        loadCase("lhu", LHU, 32'h8000_0002, 32'hBEEF_1234, 32'h0000_BEEF);
        loadCase("op7", 3'd7, 32'h8000_0008, 32'h0BAD_F00D, 32'h0BAD_F00D);

        // Halfword store into the upper lanes
        applyStimulus(1'b1, LH, 32'h8000_0002, 32'h1234_ABCD);
        checkOutput("sh_req",   mem_req,   1);
        checkOutput("sh_wmask", mem_wmask, 32'h0000_000C);
        checkOutput("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        checkOutput("sh_wen",   mem_wen,   1);
        checkOutput("sh_addr",  mem_addr,  32'h8000_0000);
        serveBus(0, 0, 32'h5555_5555);
        checkOutput("sh_valid", out_valid, 1);
        checkOutput("sh_rdata", out_rdata, 0);
        checkOutput("sh_err",   out_err,   ERR_NONE);
        releaseResp();

        // Byte store into lane 1
        applyStimulus(1'b1, LB, 32'h8000_0001, 32'h0000_00A5);
        checkOutput("sb_wmask", mem_wmask, 32'h0000_0002);
        checkOutput("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        serveBus(0, 0, 32'd0);
        checkOutput("sb_valid", out_valid, 1);
        releaseResp();

        // Misaligned word load: straight to RESP, no bus request
        checkOutput("mis_pre_req", mem_req, 0);
        applyStimulus(1'b0, LW, 32'h8000_0001, 32'd0);
        checkOutput("mis_req",   mem_req,   0);
        checkOutput("mis_valid", out_valid, 1);
        checkOutput("mis_err",   out_err,   ERR_MISALIGN);
        checkOutput("mis_rdata", out_rdata, 0);
        tick();
        checkOutput("mis_req2",  mem_req,   0);
        checkOutput("mis_hold",  out_valid, 1);
        releaseResp();

        // Misaligned halfword load
        applyStimulus(1'b0, LHU, 32'h8000_0003, 32'd0);
        checkOutput("mish_req", mem_req, 0);
        checkOutput("mish_err", out_err, ERR_MISALIGN);
        releaseResp();

        // Timeout: four WAIT cycles with no response
        applyStimulus(1'b0, LW, 32'h8000_000C, 32'd0);
        serveBus(0, -1, 32'd0);
        tick();
        tick();
        tick();
        checkOutput("to_w4_valid", out_valid, 0);
        tick();
        checkOutput("to_valid", out_valid, 1);
        checkOutput("to_err",   out_err,   ERR_TIMEOUT);
        checkOutput("to_rdata", out_rdata, 0);
        releaseResp();

        // Response on the last counted WAIT cycle still wins
        applyStimulus(1'b0, LW, 32'h8000_000C, 32'd0);
        serveBus(0, 3, 32'hCAFE_F00D);
        checkOutput("late_valid", out_valid, 1);
        checkOutput("late_err",   out_err,   ERR_NONE);
        checkOutput("late_rdata", out_rdata, 32'hCAFE_F00D);
        releaseResp();

        // Grant delayed 3 cycles, result held 5 cycles
        applyStimulus(1'b1, LW, 32'h8000_0010, 32'h1122_3344);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_req",   mem_req,   1);
            checkOutput("stall_addr",  mem_addr,  32'h8000_0010);
            checkOutput("stall_wdata", mem_wdata, 32'h1122_3344);
            checkOutput("stall_wmask", mem_wmask, 32'h0000_000F);
            checkOutput("stall_wen",   mem_wen,   1);
            tick();
        end
        checkOutput("stall_req4", mem_req, 1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        checkOutput("stall_wait_req", mem_req, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_err",   out_err,   ERR_NONE);
            checkOutput("hold_rdata", out_rdata, 0);
            checkOutput("hold_ready", in_ready,  0);
            tick();
        end
        releaseResp();
        checkOutput("hold_idle", in_ready, 1);

        // Reset in the middle of WAIT, then a stray late response
        applyStimulus(1'b0, LW, 32'h8000_0020, 32'd0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkResetValues("abort");
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        checkOutput("stray_valid", out_valid, 0);
        checkOutput("stray_rdata", out_rdata, 0);
        checkOutput("stray_ready", in_ready,  1);
        tick();
        checkOutput("stray_req",   mem_req,   0);

        // Controller still works after the abort
        loadCase("post", LW, 32'h8000_0024, 32'h0102_0304, 32'h0102_0304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller between the execute stage and the data-memory port of the multicycle core. Accepts one memory instruction per handshake. Drives a variable-latency memory request channel with byte-aligned write data and write mask. Returns sign/zero-extended load data, or a misalignment/timeout error, to write-back. Replaces the fixed single-cycle memory access of the multicycle path.

## Interface
- `TIMEOUT`, default 255: cycles to wait in WAIT before declaring a bus error; must be ≥ 1.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  execute stage presents a memory op.
- `in_ready`  out  1  controller can accept an op.
- `in_wen`  in  1  1 = store, 0 = load.
- `in_op`  in  3  funct3: 0 lb/sb, 1 lh/sh, 2 lw/sw, 4 lbu, 5 lhu.
- `in_addr`  in  32  effective address.
- `in_wdata`  in  32  store data, right-justified.
- `mem_req`  out  1  request valid.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_wen`  out  1  write request.
- `mem_addr`  out  32  word-aligned address ({in_addr[31:2],2'b00}).
- `mem_wdata`  out  32  store data shifted to its byte lane.
- `mem_wmask`  out  8  byte mask; bits [7:4] always 0.
- `mem_rvalid`  in  1  response valid (reads and writes both respond).
- `mem_rdata`  in  32  raw read word.
- `out_valid`  out  1  result ready for write-back.
- `out_ready`  in  1  write-back accepts.
- `out_rdata`  out  32  extended load result; 0 for stores and errors.
- `out_err`  out  2  0 none, 1 misaligned, 2 timeout.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: `in_ready`=1. On `in_valid`, latch wen, op, addr[1:0], and the computed wdata/wmask/address.
  - If misaligned, go to RESP with err=1 and no bus activity. Misaligned means a halfword with addr[0]=1, or a word with addr[1:0]≠0.
  - Otherwise go to REQ.
- REQ: `mem_req`=1, with fields held stable. On `mem_gnt`, go to WAIT and clear the timeout counter.
- WAIT: counter increments every cycle.
  - On `mem_rvalid`, capture `mem_rdata` and go to RESP.
  - If the counter reaches TIMEOUT−1 without `mem_rvalid`, go to RESP with err=2.
  - `mem_rvalid` wins over timeout in the same cycle.
- RESP: `out_valid`=1, outputs held stable. On `out_ready`, go to IDLE.
- Unknown `in_op` values (3, 6, 7) are treated as lw/sw.
- Store lane placement:
  - sb: wmask = 8'h01 << addr[1:0]; wdata = {4{in_wdata[7:0]}}.
  - sh: wmask = 8'h03 << addr[1:0]; wdata = {2{in_wdata[15:0]}}.
  - sw: wmask = 8'h0F; wdata = in_wdata.
- Load extraction from the captured word, using the latched addr[1:0]:
  - Byte: byte lane addr[1:0].
  - Half: bits [16·addr[1]+15 : 16·addr[1]].
  - Ops 0 and 1 sign-extend; ops 4 and 5 zero-extend; op 2 passes the word through.
- A `mem_rvalid` seen outside WAIT is ignored.

## Timing
- Reset: state IDLE.
  - in_ready=1; mem_req=0, mem_wen=0, mem_addr=0, mem_wdata=0, mem_wmask=0.
  - out_valid=0, out_rdata=0, out_err=0; counter 0.
- Minimum aligned latency, with gnt and rvalid each arriving the first cycle they can:
  - accept at edge 0, request at edge 1, response at edge 2.
  - out_valid is visible in cycle 3 (3 cycles).
- Misaligned op: out_valid is visible the cycle after accept.
- No combinational path from `in_valid` to `mem_req`, or from `mem_rvalid` to `out_valid`. All outputs are registered or decoded from state.
- `in_ready` is 0 in REQ, WAIT and RESP. There is no overlap; one op is in flight at a time.
- Reset in any state aborts the op: no further mem_req, and any pending response is dropped.
- The counter saturates and does not wrap.

## Structure
- Shared package `lsu_pkg`:
  - state enum `lsu_state_t`;
  - funct3 localparams (LB, LH, LW, LBU, LHU);
  - error codes (ERR_NONE, ERR_MISALIGN, ERR_TIMEOUT).
- One sub-module, `lsu_align`: purely combinational.
  - Store direction: computes wdata/wmask from op, data and address.
  - Load direction: performs lane extraction and extension from op, offset and word.
- The FSM, counter and registers stay in `lsu_ctrl`.

## Test plan
- Aligned lw at 0x8000_0004, gnt same cycle, rvalid one cycle later with 0xDEADBEEF → out_rdata=0xDEADBEEF, err=0, out_valid in cycle 3.
- lb at 0x8000_0003, rdata 0x80FF_0000 → out_rdata=0xFFFF_FF80; lbu at the same address → 0x0000_0080.
- sh at 0x8000_0002 with in_wdata 0x1234_ABCD → mem_wmask=8'h0C, mem_wdata=0xABCD_ABCD, mem_wen=1, out_rdata=0.
- lw at 0x8000_0001 → no mem_req ever asserted; out_err=1 on the cycle after accept.
- TIMEOUT=4, gnt given, rvalid never → out_err=2 after 4 WAIT cycles. Repeat with rvalid on the 4th WAIT cycle → err=0, data returned.
- gnt delayed 3 cycles, out_ready held low 5 cycles, and rst asserted mid-WAIT on a second op. Check:
  - mem fields stable until gnt;
  - outputs stable until out_ready;
  - after reset, all outputs are at reset values and a late rvalid is ignored.
